kmeans_sample_buf: RTL and testbench

Parametrised sample buffer for the k-means datapath. It captures one burst of input samples into on-chip storage, then replays the whole burst a programmable number of times, once per clustering iteration, over a valid/ready output stream with backpressure. It is the generalised successor of the fixed 16-bit store-and-return memory: configurable width and depth, multi-pass replay, per-pass framing, backpressure and overflow detection.

---
 rtl/kmeans_pkg.sv | 17 +
 rtl/kmeans_sample_buf_if.sv | 26 ++
 rtl/kmeans_sample_ram.sv | 23 ++
 rtl/kmeans_sample_buf.sv | 109 ++++++++++
 tb/tb_kmeans_sample_buf.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/kmeans_pkg.sv
// Shared types and helpers for the k-means sample buffer datapath.
package kmeans_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REPLAY
    } state_t;

    localparam int DATA_W_DEF = 16;

    // Counter width able to represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/kmeans_sample_buf_if.sv
// Load/replay stream bundle: the producer/consumer side uses master, the buffer uses slave.
interface kmeans_sample_buf_if #(
    parameter int DATA_W = 16,
    parameter int PASS_W = 4
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [PASS_W-1:0] num_pass;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [PASS_W-1:0] out_pass;
    logic              busy;
    logic              overflow;

    modport master (
        output in_valid, in_data, num_pass, out_ready,
        input  out_valid, out_data, out_last, out_pass, busy, overflow
    );

    modport slave (
        input  in_valid, in_data, num_pass, out_ready,
        output out_valid, out_data, out_last, out_pass, busy, overflow
    );
endinterface

// File: rtl/kmeans_sample_ram.sv
// DEPTH x DATA_W sample store: synchronous write, asynchronous read, no reset.
module kmeans_sample_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4096,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/kmeans_sample_buf.sv
// Captures one contiguous burst, then replays it eff_pass times on a valid/ready stream.
// First beat appears the cycle after the burst ends; a stalled beat holds until accepted.
module kmeans_sample_buf
    import kmeans_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4096,
    parameter int PASS_W = 4
) (
    input logic                clk,
    input logic                rst,
    kmeans_sample_buf_if.slave bus
);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int AW    = $clog2(DEPTH);

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  rd_ptr;
    logic [PASS_W-1:0] pass;
    logic [PASS_W-1:0] npass;
    logic              ovf;

    logic [PASS_W-1:0] eff_pass;
    logic              full;
    logic              is_last;
    logic              replay;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] rdata;

    assign eff_pass = (npass == '0) ? PASS_W'(1) : npass;
    assign full     = (count == CNT_W'(DEPTH));
    assign is_last  = (rd_ptr == count - CNT_W'(1));
    assign replay   = (state == ST_REPLAY);

    // Sample 0 is written straight from IDLE so the burst costs no extra cycle.
    assign we    = bus.in_valid && ((state == ST_IDLE) || ((state == ST_LOAD) && !full));
    assign waddr = (state == ST_IDLE) ? '0 : count[AW-1:0];

    kmeans_sample_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(waddr),
        .wdata(bus.in_data),
        .raddr(rd_ptr[AW-1:0]),
        .rdata(rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            count  <= '0;
            rd_ptr <= '0;
            pass   <= '0;
            npass  <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        state <= ST_LOAD;
                        count <= CNT_W'(1);
                        npass <= bus.num_pass;
                        ovf   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        if (full) begin
                            ovf <= 1'b1;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end else begin
                        state  <= ST_REPLAY;
                        rd_ptr <= '0;
                        pass   <= '0;
                    end
                end
                ST_REPLAY: begin
                    if (bus.out_ready) begin
                        if (!is_last) begin
                            rd_ptr <= rd_ptr + CNT_W'(1);
                        end else if (pass != eff_pass - PASS_W'(1)) begin
                            rd_ptr <= '0;
                            pass   <= pass + PASS_W'(1);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are gated by state so the unreset storage never leaks onto the bus.
    assign bus.out_valid = replay;
    assign bus.out_data  = replay ? rdata : '0;
    assign bus.out_last  = replay && is_last;
    assign bus.out_pass  = replay ? pass : '0;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.overflow  = ovf;
endmodule

// File: tb/tb_kmeans_sample_buf.sv
// Directed bench for kmeans_sample_buf with DEPTH=4 so the overflow path is reachable.
module tb_kmeans_sample_buf;
    localparam int DW = 16;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [DW-1:0] ld [8];

    kmeans_sample_buf_if #(.DATA_W(DW), .PASS_W(PW)) bus ();

    kmeans_sample_buf #(.DATA_W(DW), .DEPTH(4), .PASS_W(PW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives ld[0..n-1] as one burst, then the single idle cycle that ends it.
    task automatic do_load(input int n, input int np);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = ld[i];
            bus.num_pass = PW'(np);
            tick();
            if (i == 0) chk("busy_rise", 32'(bus.busy), 1);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        tick();
    endtask

    // Checks the presented beat, then lets it transfer if out_ready is high.
    task automatic beat(input string tag, input int d, input int last, input int p);
        chk({tag, "_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_data"},  32'(bus.out_data),  32'(d));
        chk({tag, "_last"},  32'(bus.out_last),  32'(last));
        chk({tag, "_pass"},  32'(bus.out_pass),  32'(p));
        tick();
    endtask

    task automatic done(input string tag);
        chk({tag, "_valid0"}, 32'(bus.out_valid), 0);
        chk({tag, "_busy0"},  32'(bus.busy),      0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.num_pass  = '0;
        bus.out_ready = 1'b1;

        #3;
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data",  32'(bus.out_data),  0);
        chk("rst_last",  32'(bus.out_last),  0);
        chk("rst_pass",  32'(bus.out_pass),  0);
        chk("rst_busy",  32'(bus.busy),      0);
        chk("rst_ovf",   32'(bus.overflow),  0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Legacy store-and-return
        ld[0] = 16'd1024; ld[1] = 16'd512;
        do_load(2, 1);
        beat("leg0", 1024, 0, 0);
        beat("leg1", 512, 1, 0);
        done("leg");

        // Three passes back to back
        ld[0] = 16'd5; ld[1] = 16'd6; ld[2] = 16'd7;
        do_load(3, 3);
        for (int p = 0; p < 3; p++) begin
            beat("mp_a", 5, 0, p);
            beat("mp_b", 6, 0, p);
            beat("mp_c", 7, 1, p);
        end
        done("mp");

        // Backpressure on the first beat
        ld[0] = 16'd1024; ld[1] = 16'd512;
        bus.out_ready = 1'b0;
        do_load(2, 1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_data",  32'(bus.out_data),  1024);
            chk("bp_last",  32'(bus.out_last),  0);
            tick();
        end
        bus.out_ready = 1'b1;
        beat("bp0", 1024, 0, 0);
        beat("bp1", 512, 1, 0);
        done("bp");

        // Overflow: six beats into four slots
        for (int i = 0; i < 6; i++) ld[i] = DW'(i + 1);
        do_load(6, 1);
        chk("ovf_set", 32'(bus.overflow), 1);
        beat("ov1", 1, 0, 0);
        beat("ov2", 2, 0, 0);
        beat("ov3", 3, 0, 0);
        beat("ov4", 4, 1, 0);
        done("ov");
        chk("ovf_sticky", 32'(bus.overflow), 1);
        ld[0] = 16'd9;
        do_load(1, 1);
        chk("ovf_clr", 32'(bus.overflow), 0);
        beat("ov9", 9, 1, 0);
        done("ov9");

        // num_pass of zero behaves as one pass
        ld[0] = 16'd42;
        do_load(1, 0);
        beat("np0", 42, 1, 0);
        done("np0");

        // in_valid during replay is ignored
        ld[0] = 16'd5; ld[1] = 16'd6;
        do_load(2, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd99;
        beat("ign0", 5, 0, 0);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        beat("ign1", 6, 1, 0);
        done("ign");

        // Asynchronous reset in the middle of the second pass
        ld[0] = 16'd1; ld[1] = 16'd2; ld[2] = 16'd3;
        do_load(3, 2);
        beat("mr0", 1, 0, 0);
        beat("mr1", 2, 0, 0);
        beat("mr2", 3, 1, 0);
        beat("mr3", 1, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_valid", 32'(bus.out_valid), 0);
        chk("mr_data",  32'(bus.out_data),  0);
        chk("mr_last",  32'(bus.out_last),  0);
        chk("mr_pass",  32'(bus.out_pass),  0);
        chk("mr_busy",  32'(bus.busy),      0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("mr_idle", 32'(bus.out_valid), 0);
        ld[0] = 16'd3; ld[1] = 16'd4;
        do_load(2, 1);
        beat("mr_a", 3, 0, 0);
        beat("mr_b", 4, 1, 0);
        done("mr");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
